// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the RISC-V datapath and a
// byte-masked data memory with synchronous (registered) read.
//
// Accepts one lb/lh/lw/lbu/lhu/sb/sh/sw request at a time.
// Request side:  req_valid/req_ready handshake, req_we, req_funct3,
//                req_addr, req_wdata.
// Response side: resp_valid (one-cycle pulse), resp_rdata (extended load
//                data, 0 for stores and errors), resp_err (misaligned
//                access or illegal funct3).
// Memory side:   mem_a (word address), mem_wd (lane-replicated store
//                data), mem_we, mem_wm (byte mask), mem_rd (read word,
//                valid the cycle after mem_a is presented).
// clk is the only clock; reset is synchronous and active-high.
module lsu_mem_port #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_we,
  output logic [3:0]      mem_wm,
  input  logic [XLEN-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            err_reg;
  logic            accept;
  logic            illegal;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_val;

  assign accept = req_valid && req_ready;

  // Legality of the incoming request; unsigned loads have no store form.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = req_addr[0];
      3'b010:  illegal = |req_addr[1:0];
      3'b100:  illegal = req_we;
      3'b101:  illegal = req_we | req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = illegal ? RESP : ISSUE;
      ISSUE:   state_next = we_reg ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state. The write strobe is also gated by reset so
  // a reset landing in ISSUE never reaches the memory.
  always_comb begin
    req_ready  = (state_reg == IDLE) && !reset;
    resp_valid = (state_reg == RESP);
    resp_err   = (state_reg == RESP) && err_reg;
    mem_we     = 1'b0;
    mem_wm     = 4'b0000;
    if (state_reg == ISSUE && we_reg && !reset) begin
      mem_we = 1'b1;
      case (funct3_reg)
        3'b000:  mem_wm = 4'b0001 << addr_reg[1:0];
        3'b001:  mem_wm = addr_reg[1] ? 4'b1100 : 4'b0011;
        default: mem_wm = 4'b1111;
      endcase
    end
  end

  // Address and replicated write data follow the latched request, so they
  // hold steady between transactions.
  assign mem_a = {addr_reg[XLEN-1:2], 2'b00};

  always_comb begin
    case (funct3_reg)
      3'b000:  mem_wd = {4{wdata_reg[7:0]}};
      3'b001:  mem_wd = {2{wdata_reg[15:0]}};
      default: mem_wd = wdata_reg;
    endcase
  end

  // Load extraction from the registered memory word.
  assign load_byte = mem_rd[{addr_reg[1:0], 3'b000} +: 8];
  assign load_half = addr_reg[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'h0, load_byte};
      3'b101:  load_val = {16'h0, load_half};
      default: load_val = mem_rd;
    endcase
  end

  // Request latch and response data. rdata is cleared on acceptance so
  // stores and errors report 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        rdata_reg  <= '0;
        err_reg    <= illegal;
      end
      if (state_reg == WAIT) rdata_reg <= load_val;
    end
  end

  assign resp_rdata = rdata_reg;

endmodule
